// File: rtl/riscv_defines.sv
// Shared RISC-V opcodes, RVC quadrant/funct3 codes and packer state.
package riscv_defines;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [1:0] C_Q0 = 2'b00;
  localparam logic [1:0] C_Q1 = 2'b01;
  localparam logic [1:0] C_Q2 = 2'b10;

  localparam logic [2:0] C3_ADDI4SPN = 3'b000;
  localparam logic [2:0] C3_LW       = 3'b010;
  localparam logic [2:0] C3_FLW      = 3'b011;
  localparam logic [2:0] C3_SW       = 3'b110;
  localparam logic [2:0] C3_FSW      = 3'b111;
  localparam logic [2:0] C3_ADDI     = 3'b000;
  localparam logic [2:0] C3_JAL      = 3'b001;
  localparam logic [2:0] C3_LI       = 3'b010;
  localparam logic [2:0] C3_LUI      = 3'b011;
  localparam logic [2:0] C3_MISC_ALU = 3'b100;
  localparam logic [2:0] C3_J        = 3'b101;
  localparam logic [2:0] C3_BEQZ     = 3'b110;
  localparam logic [2:0] C3_BNEZ     = 3'b111;
  localparam logic [2:0] C3_SLLI     = 3'b000;
  localparam logic [2:0] C3_LWSP     = 3'b010;
  localparam logic [2:0] C3_FLWSP    = 3'b011;
  localparam logic [2:0] C3_CR       = 3'b100;
  localparam logic [2:0] C3_SWSP     = 3'b110;
  localparam logic [2:0] C3_FSWSP    = 3'b111;

  typedef enum logic {
    P_EMPTY = 1'b0,
    P_HALF  = 1'b1
  } pack_state_t;

  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

  function automatic logic in_rng(input logic signed [31:0] v,
                                  input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/riscv_compressor_comb.sv
// RV32 -> RVC mapping; first matching rule wins.
// FP load/store forms are enabled by RVC_ENC_FPU_EN.
module riscv_compressor_comb
  import riscv_defines::*;
(
  input  logic [31:0] instr,
  output logic [15:0] c_instr,
  output logic        is_compressible
);

  logic [6:0] op, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic signed [31:0] ii, is, ib, ij, iu;
  logic ca;

  assign op  = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];
  assign ii  = {{20{instr[31]}}, instr[31:20]};
  assign is  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign ib  = {{19{instr[31]}}, instr[31], instr[7],
                instr[30:25], instr[11:8], 1'b0};
  assign ij  = {{11{instr[31]}}, instr[31], instr[19:12],
                instr[20], instr[30:21], 1'b0};
  assign iu  = {{12{instr[31]}}, instr[31:12]};
  assign ca  = (rd == rs1) && is_creg(rd) && is_creg(rs2);

  always_comb begin
    c_instr = 16'h0000;
    is_compressible = 1'b0;
    unique case (op)
      OPC_OP_IMM: begin
        if (f3 == 3'b000) begin
          if (rd == '0 && rs1 == '0 && ii == '0) begin
            is_compressible = 1'b1;
            c_instr = {C3_ADDI, 1'b0, 5'd0, 5'd0, C_Q1};
          end else if (rd != '0 && rd == rs1 && ii != '0
                       && in_rng(ii, -32, 31)) begin
            is_compressible = 1'b1;
            c_instr = {C3_ADDI, ii[5], rd, ii[4:0], C_Q1};
          end else if (rd != '0 && rs1 == '0 && in_rng(ii, -32, 31)) begin
            is_compressible = 1'b1;
            c_instr = {C3_LI, ii[5], rd, ii[4:0], C_Q1};
          end else if (rd == 5'd2 && rs1 == 5'd2 && ii != '0
                       && ii[3:0] == '0 && in_rng(ii, -512, 496)) begin
            is_compressible = 1'b1;
            c_instr = {C3_LUI, ii[9], 5'd2, ii[4], ii[6],
                       ii[8:7], ii[5], C_Q1};
          end else if (is_creg(rd) && rs1 == 5'd2 && ii[1:0] == '0
                       && in_rng(ii, 4, 1020)) begin
            is_compressible = 1'b1;
            c_instr = {C3_ADDI4SPN, ii[5:4], ii[9:6], ii[2], ii[3],
                       rd[2:0], C_Q0};
          end
        end else if (f3 == 3'b001) begin
          if (f7 == '0 && rd != '0 && rd == rs1 && rs2 != '0) begin
            is_compressible = 1'b1;
            c_instr = {C3_SLLI, 1'b0, rd, rs2, C_Q2};
          end
        end else if (f3 == 3'b101) begin
          if (is_creg(rd) && rd == rs1 && rs2 != '0
              && (f7 == 7'h00 || f7 == 7'h20)) begin
            is_compressible = 1'b1;
            c_instr = {C3_MISC_ALU, 1'b0, 1'b0, f7[5], rd[2:0],
                       rs2, C_Q1};
          end
        end else if (f3 == 3'b111) begin
          if (is_creg(rd) && rd == rs1 && in_rng(ii, -32, 31)) begin
            is_compressible = 1'b1;
            c_instr = {C3_MISC_ALU, ii[5], 2'b10, rd[2:0],
                       ii[4:0], C_Q1};
          end
        end
      end
      OPC_LUI: begin
        if (rd != '0 && rd != 5'd2 && iu != '0 && in_rng(iu, -32, 31)) begin
          is_compressible = 1'b1;
          c_instr = {C3_LUI, iu[5], rd, iu[4:0], C_Q1};
        end
      end
      OPC_OP: begin
        if (f3 == 3'b000 && f7 == '0 && rs1 == '0
            && rd != '0 && rs2 != '0) begin
          is_compressible = 1'b1;
          c_instr = {C3_CR, 1'b0, rd, rs2, C_Q2};
        end else if (f3 == 3'b000 && f7 == '0 && rd == rs1
                     && rd != '0 && rs2 != '0) begin
          is_compressible = 1'b1;
          c_instr = {C3_CR, 1'b1, rd, rs2, C_Q2};
        end else if (ca && f7 == 7'h20 && f3 == 3'b000) begin
          is_compressible = 1'b1;
          c_instr = {C3_MISC_ALU, 3'b011, rd[2:0], 2'b00, rs2[2:0], C_Q1};
        end else if (ca && f7 == '0 && f3 == 3'b100) begin
          is_compressible = 1'b1;
          c_instr = {C3_MISC_ALU, 3'b011, rd[2:0], 2'b01, rs2[2:0], C_Q1};
        end else if (ca && f7 == '0 && f3 == 3'b110) begin
          is_compressible = 1'b1;
          c_instr = {C3_MISC_ALU, 3'b011, rd[2:0], 2'b10, rs2[2:0], C_Q1};
        end else if (ca && f7 == '0 && f3 == 3'b111) begin
          is_compressible = 1'b1;
          c_instr = {C3_MISC_ALU, 3'b011, rd[2:0], 2'b11, rs2[2:0], C_Q1};
        end
      end
      OPC_LOAD: begin
        if (f3 == 3'b010 && is_creg(rd) && is_creg(rs1)
            && ii[1:0] == '0 && in_rng(ii, 0, 124)) begin
          is_compressible = 1'b1;
          c_instr = {C3_LW, ii[5:3], rs1[2:0], ii[2], ii[6], rd[2:0], C_Q0};
        end else if (f3 == 3'b010 && rs1 == 5'd2 && rd != '0
                     && ii[1:0] == '0 && in_rng(ii, 0, 252)) begin
          is_compressible = 1'b1;
          c_instr = {C3_LWSP, ii[5], rd, ii[4:2], ii[7:6], C_Q2};
        end
      end
      OPC_STORE: begin
        if (f3 == 3'b010 && is_creg(rs2) && is_creg(rs1)
            && is[1:0] == '0 && in_rng(is, 0, 124)) begin
          is_compressible = 1'b1;
          c_instr = {C3_SW, is[5:3], rs1[2:0], is[2], is[6], rs2[2:0], C_Q0};
        end else if (f3 == 3'b010 && rs1 == 5'd2
                     && is[1:0] == '0 && in_rng(is, 0, 252)) begin
          is_compressible = 1'b1;
          c_instr = {C3_SWSP, is[5:2], is[7:6], rs2, C_Q2};
        end
      end
`ifdef RVC_ENC_FPU_EN
      OPC_LOAD_FP: begin
        if (f3 == 3'b010 && is_creg(rd) && is_creg(rs1)
            && ii[1:0] == '0 && in_rng(ii, 0, 124)) begin
          is_compressible = 1'b1;
          c_instr = {C3_FLW, ii[5:3], rs1[2:0], ii[2], ii[6], rd[2:0], C_Q0};
        end else if (f3 == 3'b010 && rs1 == 5'd2
                     && ii[1:0] == '0 && in_rng(ii, 0, 252)) begin
          is_compressible = 1'b1;
          c_instr = {C3_FLWSP, ii[5], rd, ii[4:2], ii[7:6], C_Q2};
        end
      end
      OPC_STORE_FP: begin
        if (f3 == 3'b010 && is_creg(rs2) && is_creg(rs1)
            && is[1:0] == '0 && in_rng(is, 0, 124)) begin
          is_compressible = 1'b1;
          c_instr = {C3_FSW, is[5:3], rs1[2:0], is[2], is[6], rs2[2:0], C_Q0};
        end else if (f3 == 3'b010 && rs1 == 5'd2
                     && is[1:0] == '0 && in_rng(is, 0, 252)) begin
          is_compressible = 1'b1;
          c_instr = {C3_FSWSP, is[5:2], is[7:6], rs2, C_Q2};
        end
      end
`endif
      OPC_JAL: begin
        if ((rd == 5'd0 || rd == 5'd1) && in_rng(ij, -2048, 2046)) begin
          is_compressible = 1'b1;
          c_instr = {(rd[0] ? C3_JAL : C3_J), ij[11], ij[4], ij[9:8],
                     ij[10], ij[6], ij[7], ij[3:1], ij[5], C_Q1};
        end
      end
      OPC_JALR: begin
        if (f3 == 3'b000 && (rd == 5'd0 || rd == 5'd1)
            && rs1 != '0 && ii == '0) begin
          is_compressible = 1'b1;
          c_instr = {C3_CR, rd[0], rs1, 5'd0, C_Q2};
        end
      end
      OPC_BRANCH: begin
        if ((f3 == 3'b000 || f3 == 3'b001) && rs2 == '0
            && is_creg(rs1) && in_rng(ib, -256, 254)) begin
          is_compressible = 1'b1;
          c_instr = {(f3[0] ? C3_BNEZ : C3_BEQZ), ib[8], ib[4:3],
                     rs1[2:0], ib[7:6], ib[2:1], ib[5], C_Q1};
        end
      end
      OPC_SYSTEM: begin
        if (instr == 32'h0010_0073) begin
          is_compressible = 1'b1;
          c_instr = {C3_CR, 1'b1, 5'd0, 5'd0, C_Q2};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_compressed_encoder.sv
// Compresses RV32 instructions and packs them into 32-bit fetch words.
// Define RVC_ENC_FPU_EN to also compress flw/fsw forms.
module riscv_compressed_encoder
  import riscv_defines::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  input  logic [31:0]        in_instr_i,
  output logic               in_ready_o,
  input  logic               flush_i,
  output logic               out_valid_o,
  output logic [31:0]        out_data_o,
  input  logic               out_ready_i,
  output logic               illegal_o,
  output logic [COUNT_W-1:0] cnt_compressed_o
);

  pack_state_t state_q, state_d;
  logic [15:0] hold_q, hold_d, c_instr;
  logic [31:0] emit_data;
  logic is_c, slot_free, flush_act, accept, bad, take;
  logic emit, hold_we;

  riscv_compressor_comb u_comb (
    .instr           (in_instr_i),
    .c_instr         (c_instr),
    .is_compressible (is_c)
  );

  assign slot_free  = !out_valid_o || out_ready_i;
  assign flush_act  = flush_i && (state_q == P_HALF) && slot_free;
  assign in_ready_o = slot_free && !flush_act;
  assign accept     = in_valid_i && in_ready_o;
  assign bad        = in_instr_i[1:0] != 2'b11;
  assign take       = accept && !bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= P_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_act)
      state_d = P_EMPTY;
    else if (take && is_c)
      state_d = (state_q == P_EMPTY) ? P_HALF : P_EMPTY;
  end

  always_comb begin
    emit      = 1'b0;
    emit_data = '0;
    hold_we   = 1'b0;
    hold_d    = hold_q;
    if (flush_act) begin
      emit      = 1'b1;
      emit_data = {16'h0001, hold_q};
    end else if (take) begin
      unique case (state_q)
        P_EMPTY: begin
          if (is_c) begin
            hold_we = 1'b1;
            hold_d  = c_instr;
          end else begin
            emit      = 1'b1;
            emit_data = in_instr_i;
          end
        end
        P_HALF: begin
          emit = 1'b1;
          if (is_c) begin
            emit_data = {c_instr, hold_q};
          end else begin
            emit_data = {in_instr_i[15:0], hold_q};
            hold_we   = 1'b1;
            hold_d    = in_instr_i[31:16];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q           <= '0;
      out_valid_o      <= 1'b0;
      out_data_o       <= '0;
      illegal_o        <= 1'b0;
      cnt_compressed_o <= '0;
    end else begin
      if (hold_we) hold_q <= hold_d;
      if (emit) begin
        out_valid_o <= 1'b1;
        out_data_o  <= emit_data;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      illegal_o <= accept && bad;
      if (take && is_c && cnt_compressed_o != '1)
        cnt_compressed_o <= cnt_compressed_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_compressed_encoder.sv
// Directed bench for riscv_compressed_encoder (narrow counter to reach saturation).
module tb_riscv_compressed_encoder;

  localparam int CW = 4;
  localparam int NR = 25;

  // {compressible, expected 16-bit encoding, RV32 instruction}
  localparam logic [48:0] RULES [NR] = '{
    {1'b1, 16'h0001, 32'h0000_0013},
    {1'b1, 16'h557D, 32'hFFF0_0513},
    {1'b1, 16'h1141, 32'hFF01_0113},
    {1'b1, 16'h6121, 32'h0401_0113},
    {1'b1, 16'h0800, 32'h0101_0413},
    {1'b1, 16'h6785, 32'h0000_17B7},
    {1'b1, 16'h852E, 32'h00B0_0533},
    {1'b1, 16'h952E, 32'h00B5_0533},
    {1'b1, 16'h8C05, 32'h4094_0433},
    {1'b1, 16'h4044, 32'h0044_2483},
    {1'b1, 16'hC606, 32'h0011_2623},
    {1'b1, 16'hBFFD, 32'hFFFF_F06F},
    {1'b1, 16'h8082, 32'h0000_8067},
    {1'b1, 16'hC401, 32'h0004_0463},
    {1'b1, 16'h9002, 32'h0010_0073},
    {1'b1, 16'h840D, 32'h4034_5413},
    {1'b1, 16'h98FD, 32'hFFF4_F493},
    {1'b1, 16'h050A, 32'h0025_1513},
    {1'b1, 16'h2801, 32'h0100_00EF},
    {1'b1, 16'h5C64, 32'h07C4_2483},
    {1'b0, 16'h0000, 32'h0204_0413},
    {1'b0, 16'h0000, 32'h0804_2483},
    {1'b0, 16'h0000, 32'h1004_0063},
    {1'b0, 16'h0000, 32'h0001_0413},
    {1'b0, 16'h0000, 32'h0010_006F}
  };

  logic clk, rst_n;
  logic in_valid_i, in_ready_o, flush_i;
  logic out_valid_o, out_ready_i, illegal_o;
  logic [31:0] in_instr_i, out_data_o;
  logic [CW-1:0] cnt_compressed_o, exp_cnt;
  int nvec, nerr;

  riscv_compressed_encoder #(.COUNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid_i       (in_valid_i),
    .in_instr_i       (in_instr_i),
    .in_ready_o       (in_ready_o),
    .flush_i          (flush_i),
    .out_valid_o      (out_valid_o),
    .out_data_o       (out_data_o),
    .out_ready_i      (out_ready_i),
    .illegal_o        (illegal_o),
    .cnt_compressed_o (cnt_compressed_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic bump();
    if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic drive(input logic [31:0] ins);
    @(negedge clk);
    in_valid_i = 1'b1;
    in_instr_i = ins;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    nvec++;
    if (out_valid_o !== 1'b0) begin
      nerr++; $display("FAIL rst_valid: got %b want 0", out_valid_o);
    end
    nvec++;
    if (out_data_o !== 32'h0) begin
      nerr++; $display("FAIL rst_data: got %h want 0", out_data_o);
    end
    nvec++;
    if (illegal_o !== 1'b0) begin
      nerr++; $display("FAIL rst_illegal: got %b want 0", illegal_o);
    end
    nvec++;
    if (cnt_compressed_o !== '0) begin
      nerr++; $display("FAIL rst_cnt: got %0d want 0", cnt_compressed_o);
    end
    nvec++;
    if (in_ready_o !== 1'b1) begin
      nerr++; $display("FAIL rst_ready: got %b want 1", in_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_pair();
    drive(32'h0014_0413);
    bump();
    nvec++;
    if (out_valid_o !== 1'b0) begin
      nerr++; $display("FAIL pair_first: got %b want 0", out_valid_o);
    end
    drive(32'h0014_0413);
    bump();
    nvec++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h0405_0405) begin
      nerr++;
      $display("FAIL pair_word: got %b/%h want 1/04050405",
               out_valid_o, out_data_o);
    end
    nvec++;
    if (cnt_compressed_o !== exp_cnt) begin
      nerr++; $display("FAIL pair_cnt: got %0d want %0d",
                       cnt_compressed_o, exp_cnt);
    end
    idle();
    nvec++;
    if (out_valid_o !== 1'b0) begin
      nerr++; $display("FAIL pair_drain: got %b want 0", out_valid_o);
    end
  endtask

  task automatic test_passthrough();
    drive(32'h1234_52B7);
    nvec++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h1234_52B7) begin
      nerr++;
      $display("FAIL pass_word: got %b/%h want 1/123452b7",
               out_valid_o, out_data_o);
    end
    nvec++;
    if (cnt_compressed_o !== exp_cnt) begin
      nerr++; $display("FAIL pass_cnt: got %0d want %0d",
                       cnt_compressed_o, exp_cnt);
    end
  endtask

  task automatic test_flush();
    drive(32'h0014_0413);
    bump();
    drive(32'h1234_52B7);
    nvec++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h52B7_0405) begin
      nerr++;
      $display("FAIL split_word: got %b/%h want 1/52b70405",
               out_valid_o, out_data_o);
    end
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    nvec++;
    if (in_ready_o !== 1'b0) begin
      nerr++; $display("FAIL flush_ready: got %b want 0", in_ready_o);
    end
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    nvec++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h0001_1234) begin
      nerr++;
      $display("FAIL flush_word: got %b/%h want 1/00011234",
               out_valid_o, out_data_o);
    end
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    nvec++;
    if (in_ready_o !== 1'b1) begin
      nerr++; $display("FAIL flush_empty_ready: got %b want 1", in_ready_o);
    end
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    nvec++;
    if (out_valid_o !== 1'b0) begin
      nerr++; $display("FAIL flush_empty: got %b want 0", out_valid_o);
    end
    nvec++;
    if (cnt_compressed_o !== exp_cnt) begin
      nerr++; $display("FAIL flush_cnt: got %0d want %0d",
                       cnt_compressed_o, exp_cnt);
    end
  endtask

  task automatic test_stall();
    idle();
    @(negedge clk);
    out_ready_i = 1'b0;
    drive(32'h1234_52B7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid_i = 1'b1;
      in_instr_i = 32'h0014_0413;
      #1;
      nvec++;
      if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1
          || out_data_o !== 32'h1234_52B7) begin
        nerr++;
        $display("FAIL stall_%0d: got rdy=%b v=%b d=%h want 0/1/123452b7",
                 i, in_ready_o, out_valid_o, out_data_o);
      end
    end
    @(negedge clk);
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    bump();
    nvec++;
    if (out_valid_o !== 1'b0) begin
      nerr++; $display("FAIL stall_release: got %b want 0", out_valid_o);
    end
    do_flush();
    nvec++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h0001_0405) begin
      nerr++;
      $display("FAIL stall_flush: got %b/%h want 1/00010405",
               out_valid_o, out_data_o);
    end
  endtask

  task automatic test_illegal();
    drive(32'h0000_0001);
    nvec++;
    if (illegal_o !== 1'b1 || out_valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL ill_empty: got ill=%b v=%b want 1/0",
               illegal_o, out_valid_o);
    end
    do_flush();
    nvec++;
    if (illegal_o !== 1'b0 || out_valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL ill_after: got ill=%b v=%b want 0/0",
               illegal_o, out_valid_o);
    end
    drive(32'h0014_0413);
    bump();
    drive(32'h0000_0001);
    nvec++;
    if (illegal_o !== 1'b1 || out_valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL ill_half: got ill=%b v=%b want 1/0",
               illegal_o, out_valid_o);
    end
    do_flush();
    nvec++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h0001_0405) begin
      nerr++;
      $display("FAIL ill_hold: got %b/%h want 1/00010405",
               out_valid_o, out_data_o);
    end
    nvec++;
    if (cnt_compressed_o !== exp_cnt) begin
      nerr++; $display("FAIL ill_cnt: got %0d want %0d",
                       cnt_compressed_o, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid_i = 1'b1;
    in_instr_i = 32'h0014_0413;
    @(posedge clk);
    #1;
    bump();
    nvec++;
    if (out_valid_o !== 1'b0) begin
      nerr++; $display("FAIL b2b_0: got %b want 0", out_valid_o);
    end
    in_instr_i = 32'h1234_52B7;
    @(posedge clk);
    #1;
    nvec++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h52B7_0405) begin
      nerr++;
      $display("FAIL b2b_1: got %b/%h want 1/52b70405",
               out_valid_o, out_data_o);
    end
    in_instr_i = 32'h0014_0413;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    bump();
    nvec++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h0405_1234) begin
      nerr++;
      $display("FAIL b2b_2: got %b/%h want 1/04051234",
               out_valid_o, out_data_o);
    end
  endtask

  task automatic test_rules();
    logic [48:0] e;
    logic [31:0] ins, want, got;
    for (int k = 0; k < NR; k++) begin
      e    = RULES[k];
      ins  = e[31:0];
      want = e[48] ? {16'h0001, e[47:32]} : ins;
      got  = 32'h0;
      drive(ins);
      if (!e[48]) got = out_data_o;
      nvec++;
      if (out_valid_o !== !e[48]) begin
        nerr++; $display("FAIL rule%0d_v0: got %b want %b",
                         k, out_valid_o, !e[48]);
      end
      if (e[48]) bump();
      do_flush();
      if (e[48]) got = out_data_o;
      nvec++;
      if (out_valid_o !== e[48] || got !== want) begin
        nerr++; $display("FAIL rule%0d: got %b/%h want %b/%h",
                         k, out_valid_o, got, e[48], want);
      end
    end
    nvec++;
    if (cnt_compressed_o !== exp_cnt) begin
      nerr++; $display("FAIL sat_cnt: got %0d want %0d",
                       cnt_compressed_o, exp_cnt);
    end
  endtask

  task automatic test_fpu();
    drive(32'h0004_A407);
`ifdef RVC_ENC_FPU_EN
    bump();
    nvec++;
    if (out_valid_o !== 1'b0) begin
      nerr++; $display("FAIL fpu_hold: got %b want 0", out_valid_o);
    end
    do_flush();
    nvec++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h0001_6080) begin
      nerr++;
      $display("FAIL fpu_word: got %b/%h want 1/00016080",
               out_valid_o, out_data_o);
    end
`else
    nvec++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h0004_A407) begin
      nerr++;
      $display("FAIL fpu_pass: got %b/%h want 1/0004a407",
               out_valid_o, out_data_o);
    end
    do_flush();
`endif
    nvec++;
    if (cnt_compressed_o !== exp_cnt) begin
      nerr++; $display("FAIL fpu_cnt: got %0d want %0d",
                       cnt_compressed_o, exp_cnt);
    end
  endtask

  task automatic test_mid_reset();
    drive(32'h0014_0413);
    drive(32'h1234_52B7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++;
    if (out_valid_o !== 1'b0 || out_data_o !== 32'h0
        || cnt_compressed_o !== '0) begin
      nerr++;
      $display("FAIL mid_rst: got v=%b d=%h c=%0d want 0/0/0",
               out_valid_o, out_data_o, cnt_compressed_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_flush();
    nvec++;
    if (out_valid_o !== 1'b0) begin
      nerr++; $display("FAIL mid_rst_hold: got %b want 0", out_valid_o);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    exp_cnt = '0;
    in_valid_i = 1'b0;
    in_instr_i = 32'h0;
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    test_reset();
    test_pair();
    test_passthrough();
    test_flush();
    test_stall();
    test_illegal();
    test_back_to_back();
    test_rules();
    test_fpu();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/riscv_compressed_encoder.md
RISCV_COMPRESSED_ENCODER -- requirements
Module: riscv_compressed_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, ports `clk` and `rst_n`.
REQ-002 Parameter COUNT_W, default 16: width of the compressed-instruction counter.
REQ-003 clk  in  1  clock.
REQ-004 rst_n  in  1  async active-low reset.
REQ-005 in_valid_i  in  1  input instruction valid.
REQ-006 in_instr_i  in  32  RV32 instruction.
REQ-007 in_ready_o  out  1  input accepted when high with in_valid_i.
REQ-008 flush_i  in  1  request to emit the pending halfword.
REQ-009 out_valid_o  out  1  packed word valid.
REQ-010 out_data_o  out  32  packed fetch word; first halfword in [15:0].
REQ-011 out_ready_i  in  1  consumer ready.
REQ-012 illegal_o  out  1  one-cycle pulse: rejected input.
REQ-013 cnt_compressed_o  out  COUNT_W  saturating count of compressed instructions.

Function
REQ-014 Each accepted instruction SHALL map to a standard RVC 16-bit encoding when one rule matches, else pass through as 32 bits:
- c.nop: addi x0,x0,0.
- c.addi: addi rd,rd,imm; rd!=0; imm!=0; imm in [-32,31].
- c.li: addi rd,x0,imm; rd!=0; imm in [-32,31].
- c.addi16sp: addi x2,x2,imm; imm!=0; imm%16==0; imm in [-512,496].
- c.addi4spn: addi rd',x2,imm; imm%4==0; imm in [4,1020].
- c.lui: lui rd; rd not in {0,2}; imm!=0; imm fits signed 6 bits.
- c.mv: add rd,x0,rs2.
- c.add: add rd,rd,rs2.
- c.mv and c.add: rd!=0, rs2!=0.
- c.slli: rd!=0, shamt!=0.
- c.srli, c.srai, c.andi: rd'=rs1'; shamt!=0 for the shifts.
- c.sub, c.xor, c.or, c.and: rd'=rs1'.
- c.lw, c.sw: offset%4==0, in [0,124].
- c.lwsp (rd!=0), c.swsp: base x2, offset%4==0, in [0,252].
- c.j, c.jal: jal x0 or x1, offset in [-2048,2046].
- c.jr, c.jalr: jalr x0 or x1, rs1!=0, offset 0.
- c.beqz, c.bnez: beq/bne rs1',x0, offset in [-256,254].
- c.ebreak: ebreak.
REQ-015 Where several rules match, the rule listed first in REQ-014 SHALL win.
REQ-016 Packer FSM states SHALL be P_EMPTY (no pending halfword) and P_HALF (hold register holds one halfword).
REQ-017 P_EMPTY with a 16-bit result: store it in hold, go to P_HALF, emit nothing.
REQ-018 P_EMPTY with a 32-bit result: emit the instruction unchanged, stay in P_EMPTY.
REQ-019 P_HALF with a 16-bit result: emit {new,hold}, go to P_EMPTY.
REQ-020 P_HALF with a 32-bit result: emit {instr[15:0],hold}, set hold=instr[31:16], stay in P_HALF.
REQ-021 The output is a single register. Slot free = !out_valid_o || out_ready_i. in_ready_o = slot free && !flush action.
REQ-022 Latency SHALL be one cycle from input handshake to out_valid_o for every emitting case.
REQ-023 While out_valid_o=1 and out_ready_i=0, out_data_o SHALL be held stable.
REQ-024 Flush action: flush_i=1, state P_HALF, slot free. It SHALL emit {16'h0001,hold}, go to P_EMPTY, and drive in_ready_o=0 that cycle. Flush has priority over input.
REQ-025 flush_i in P_EMPTY SHALL be a no-op.
REQ-026 An input with in_instr_i[1:0]!=2'b11 SHALL be consumed and pulse illegal_o next cycle. It emits nothing and leaves state and counter unchanged.
REQ-027 cnt_compressed_o SHALL increment per accepted 16-bit result and saturate at all-ones.

Reset
REQ-028 On reset, all of the following SHALL be 0: state (P_EMPTY), hold, out_valid_o, out_data_o, illegal_o, cnt_compressed_o.
REQ-029 Reset mid-operation SHALL discard the pending halfword and the output word.

Configuration
REQ-030 With RVC_ENC_FPU_EN defined, flw/fsw SHALL compress under the c.lw/c.sw rules and the x2-based forms under the c.lwsp/c.swsp rules. flw/fsw on x2 SHALL compress to c.flwsp/c.fswsp.
REQ-031 Without RVC_ENC_FPU_EN, all FP loads/stores SHALL pass through as 32 bits.

Structure
REQ-032 Opcode constants SHALL come from riscv_defines. The packer state enum and the RVC quadrant/funct3 constants SHALL be added there.
REQ-033 The REQ-014 mapping SHALL be a combinational sub-module, riscv_compressor_comb, returning a 16-bit encoding and an is_compressible flag.

Verification
REQ-034 Inputs 0x00140413 twice -> one output word 0x04050405; cnt=2.
REQ-035 Input 0x123452B7 in P_EMPTY -> out_data 0x123452B7 one cycle later.
REQ-036 Input 0x00140413 then 0x123452B7 -> output 0x52B70405, hold 0x1234. Then flush_i -> output 0x00011234, state P_EMPTY.
REQ-037 out_ready_i=0 for 5 cycles with out_valid_o=1 -> out_data_o stable and in_ready_o=0 throughout.
REQ-038 Input 0x00000001 -> illegal_o pulse, no output, state unchanged.
REQ-039 Input 0x0004A407 -> hold 0x6080 with RVC_ENC_FPU_EN defined; passthrough 0x0004A407 without it.
